// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Includes the fetch FSM state encoding, the reset NOP and the PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2,
    S_HOLD    = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN = 32'h00000013;
  localparam int          PC_INCR  = 4;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register with load / bubble / hold control.
// Load wins over bubble; a bubble clears valid but keeps the payload.
module if_id_register
  import fetch_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int INSN_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_load,
  input  logic                      in_bubble,
  input  logic [INSN_WIDTH-1:0]     in_insn,
  input  logic [BUS_DATA_WIDTH-1:0] in_pc,
  output logic [INSN_WIDTH-1:0]     out_insn,
  output logic [BUS_DATA_WIDTH-1:0] out_pc,
  output logic                      out_valid
);

  logic [INSN_WIDTH-1:0]     r_insn;
  logic [BUS_DATA_WIDTH-1:0] r_pc;
  logic                      r_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_insn  <= INSN_WIDTH'(NOP_INSN);
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (in_load) begin
      r_insn  <= in_insn;
      r_pc    <= in_pc;
      r_valid <= 1'b1;
    end else if (in_bubble) begin
      r_valid <= 1'b0;
    end
  end

  assign out_insn  = r_insn;
  assign out_pc    = r_pc;
  assign out_valid = r_valid;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, handshakes with the I-cache and feeds IF/ID.
// A one-entry skid buffer catches a response that arrives while decode is blocked.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter int                        INSN_WIDTH     = 32,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_stall,
  input  logic                      in_stall_from_dcache,
  input  logic                      in_redirect_valid,
  input  logic [BUS_DATA_WIDTH-1:0] in_redirect_pc,
  output logic                      out_icache_req,
  output logic [BUS_DATA_WIDTH-1:0] out_icache_addr,
  input  logic                      in_icache_resp_valid,
  input  logic [INSN_WIDTH-1:0]     in_icache_resp_insn,
  output logic                      out_stall_from_icache,
  output logic [INSN_WIDTH-1:0]     out_insn,
  output logic [BUS_DATA_WIDTH-1:0] out_pc,
  output logic                      out_valid
);

  fetch_state_t              r_state, w_state_next;
  logic [BUS_DATA_WIDTH-1:0] r_pc, w_pc_next;
  logic [INSN_WIDTH-1:0]     r_skid_insn;
  logic [BUS_DATA_WIDTH-1:0] r_skid_pc;

  logic                      w_blocked;
  logic [BUS_DATA_WIDTH-1:0] w_redirect_tgt;
  logic [BUS_DATA_WIDTH-1:0] w_pc_plus;
  logic                      w_skid_load;
  logic                      w_ifid_load;
  logic                      w_ifid_bubble;
  logic [INSN_WIDTH-1:0]     w_ifid_insn;
  logic [BUS_DATA_WIDTH-1:0] w_ifid_pc;

  assign w_blocked      = in_stall | in_stall_from_dcache;
  assign w_redirect_tgt = in_redirect_pc & ~BUS_DATA_WIDTH'(3);
  assign w_pc_plus      = r_pc + BUS_DATA_WIDTH'(PC_INCR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_skid_insn <= '0;
      r_skid_pc   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_skid_load) begin
        r_skid_insn <= in_icache_resp_insn;
        r_skid_pc   <= r_pc;
      end
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_pc_next             = r_pc;
    w_skid_load           = 1'b0;
    w_ifid_load           = 1'b0;
    w_ifid_bubble         = 1'b0;
    w_ifid_insn           = in_icache_resp_insn;
    w_ifid_pc             = r_pc;
    out_icache_req        = 1'b0;
    out_stall_from_icache = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        out_stall_from_icache = 1'b1;
        w_state_next          = S_WAIT;
      end
      S_WAIT: begin
        out_icache_req        = 1'b1;
        out_stall_from_icache = ~in_icache_resp_valid;
        if (in_redirect_valid) begin
          // A response in the redirect cycle is wrong-path; with none, one is still owed.
          w_pc_next     = w_redirect_tgt;
          w_ifid_bubble = 1'b1;
          w_state_next  = in_icache_resp_valid ? S_WAIT : S_DISCARD;
        end else if (in_icache_resp_valid) begin
          w_pc_next = w_pc_plus;
          if (w_blocked) begin
            w_skid_load  = 1'b1;
            w_state_next = S_HOLD;
          end else begin
            w_ifid_load = 1'b1;
          end
        end else if (!w_blocked) begin
          w_ifid_bubble = 1'b1;
        end
      end
      S_DISCARD: begin
        out_stall_from_icache = 1'b1;
        if (in_redirect_valid) w_pc_next = w_redirect_tgt;
        if (in_icache_resp_valid) w_state_next = S_WAIT;
        if (!w_blocked) w_ifid_bubble = 1'b1;
      end
      S_HOLD: begin
        w_ifid_insn = r_skid_insn;
        w_ifid_pc   = r_skid_pc;
        if (in_redirect_valid) begin
          w_pc_next     = w_redirect_tgt;
          w_ifid_bubble = 1'b1;
          w_state_next  = S_WAIT;
        end else if (!w_blocked) begin
          w_ifid_load  = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign out_icache_addr = r_pc;

  if_id_register #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH),
    .INSN_WIDTH    (INSN_WIDTH)
  ) u_if_id (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_load  (w_ifid_load),
    .in_bubble(w_ifid_bubble),
    .in_insn  (w_ifid_insn),
    .in_pc    (w_ifid_pc),
    .out_insn (out_insn),
    .out_pc   (out_pc),
    .out_valid(out_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: inputs change on negedge,
// outputs are sampled 1 time unit later, well clear of the rising edge.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_stall, in_stall_from_dcache;
  logic        in_redirect_valid;
  logic [63:0] in_redirect_pc;
  logic        out_icache_req;
  logic [63:0] out_icache_addr;
  logic        in_icache_resp_valid;
  logic [31:0] in_icache_resp_insn;
  logic        out_stall_from_icache;
  logic [31:0] out_insn;
  logic [63:0] out_pc;
  logic        out_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage #(
    .BUS_DATA_WIDTH(64),
    .INSN_WIDTH    (32),
    .RESET_PC      (64'h1000)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .in_stall             (in_stall),
    .in_stall_from_dcache (in_stall_from_dcache),
    .in_redirect_valid    (in_redirect_valid),
    .in_redirect_pc       (in_redirect_pc),
    .out_icache_req       (out_icache_req),
    .out_icache_addr      (out_icache_addr),
    .in_icache_resp_valid (in_icache_resp_valid),
    .in_icache_resp_insn  (in_icache_resp_insn),
    .out_stall_from_icache(out_stall_from_icache),
    .out_insn             (out_insn),
    .out_pc               (out_pc),
    .out_valid            (out_valid)
  );

  task automatic drive(input logic rv, input logic [31:0] insn, input logic st,
                       input logic redir, input logic [63:0] tgt);
    @(negedge clk);
    in_icache_resp_valid = rv;
    in_icache_resp_insn  = insn;
    in_stall             = st;
    in_redirect_valid    = redir;
    in_redirect_pc       = tgt;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_stall = 0; in_stall_from_dcache = 0; in_redirect_valid = 0;
    in_redirect_pc = '0; in_icache_resp_valid = 0; in_icache_resp_insn = '0;
    #12;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_insn !== 32'h00000013) begin fails++; $display("FAIL reset_insn got %h exp 00000013", out_insn); end
    tests++; if (out_pc !== 64'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    tests++; if (out_icache_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", out_icache_req); end
    tests++; if (out_stall_from_icache !== 1'b1) begin fails++; $display("FAIL reset_stall got %b exp 1", out_stall_from_icache); end
    @(negedge clk); reset_n = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_fetch();
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_icache_req !== 1'b1 || out_icache_addr !== 64'h1000) begin fails++; $display("FAIL fetch_req0 got req=%b addr=%h exp 1/1000", out_icache_req, out_icache_addr); end
    tests++; if (out_stall_from_icache !== 1'b1) begin fails++; $display("FAIL fetch_stall_wait got %b exp 1", out_stall_from_icache); end
    drive(1, 32'h00500093, 0, 0, 64'h0);
    tests++; if (out_stall_from_icache !== 1'b0) begin fails++; $display("FAIL fetch_stall_resp got %b exp 0", out_stall_from_icache); end
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_pc !== 64'h1000 || out_insn !== 32'h00500093 || out_valid !== 1'b1) begin fails++; $display("FAIL fetch_ifid0 got %h/%h/%b exp 1000/00500093/1", out_pc, out_insn, out_valid); end
    tests++; if (out_icache_addr !== 64'h1004) begin fails++; $display("FAIL fetch_addr1 got %h exp 1004", out_icache_addr); end
    drive(1, 32'h00A00113, 0, 0, 64'h0);
    drive(0, 32'h0, 1, 0, 64'h0);
    tests++; if (out_pc !== 64'h1004 || out_insn !== 32'h00A00113 || out_valid !== 1'b1) begin fails++; $display("FAIL fetch_ifid1 got %h/%h/%b exp 1004/00a00113/1", out_pc, out_insn, out_valid); end
    tests++; if (out_icache_addr !== 64'h1008) begin fails++; $display("FAIL fetch_addr2 got %h exp 1008", out_icache_addr); end
    $display("[TB] fetch 1000/1004 checked");
  endtask

  task automatic test_stall();
    drive(1, 32'h00F00193, 1, 0, 64'h0);
    tests++; if (out_pc !== 64'h1004 || out_valid !== 1'b1) begin fails++; $display("FAIL stall_hold0 got %h/%b exp 1004/1", out_pc, out_valid); end
    drive(0, 32'h0, 1, 0, 64'h0);
    tests++; if (out_icache_req !== 1'b0 || out_pc !== 64'h1004) begin fails++; $display("FAIL stall_hold1 got req=%b pc=%h exp 0/1004", out_icache_req, out_pc); end
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_icache_req !== 1'b0 || out_pc !== 64'h1004 || out_insn !== 32'h00A00113) begin fails++; $display("FAIL stall_hold2 got req=%b pc=%h insn=%h exp 0/1004/00a00113", out_icache_req, out_pc, out_insn); end
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_pc !== 64'h1008 || out_insn !== 32'h00F00193 || out_valid !== 1'b1) begin fails++; $display("FAIL stall_release got %h/%h/%b exp 1008/00f00193/1", out_pc, out_insn, out_valid); end
    tests++; if (out_icache_req !== 1'b1 || out_icache_addr !== 64'h100C) begin fails++; $display("FAIL stall_next_addr got req=%b addr=%h exp 1/100c", out_icache_req, out_icache_addr); end
    $display("[TB] stall with skid checked");
  endtask

  task automatic test_redirect_with_resp();
    drive(1, 32'h00000033, 1, 1, 64'h3000);
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_resp_valid got %b exp 0", out_valid); end
    tests++; if (out_icache_req !== 1'b1 || out_icache_addr !== 64'h3000) begin fails++; $display("FAIL redir_resp_addr got req=%b addr=%h exp 1/3000", out_icache_req, out_icache_addr); end
    tests++; if (out_pc !== 64'h1008) begin fails++; $display("FAIL redir_resp_pc got %h exp 1008", out_pc); end
    $display("[TB] redirect with response checked");
  endtask

  task automatic test_redirect_discard();
    drive(0, 32'h0, 0, 1, 64'h2002);
    drive(1, 32'hDEADBEEF, 0, 0, 64'h0);
    tests++; if (out_icache_req !== 1'b0 || out_stall_from_icache !== 1'b1) begin fails++; $display("FAIL discard_state got req=%b stall=%b exp 0/1", out_icache_req, out_stall_from_icache); end
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_icache_req !== 1'b1 || out_icache_addr !== 64'h2000) begin fails++; $display("FAIL discard_addr got req=%b addr=%h exp 1/2000", out_icache_req, out_icache_addr); end
    tests++; if (out_valid !== 1'b0 || out_insn === 32'hDEADBEEF) begin fails++; $display("FAIL discard_drop got valid=%b insn=%h exp 0/not deadbeef", out_valid, out_insn); end
    $display("[TB] redirect discard checked");
  endtask

  task automatic test_pc_wrap();
    drive(1, 32'h00000033, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_icache_addr !== 64'hFFFF_FFFF_FFFF_FFFC || out_stall_from_icache !== 1'b1) begin fails++; $display("FAIL wrap_wait got addr=%h stall=%b exp fffffffffffffffc/1", out_icache_addr, out_stall_from_icache); end
    tests++; if (out_insn === 32'h00000033 && out_valid === 1'b1) begin fails++; $display("FAIL wrap_no_wrongpath got insn=%h valid=%b exp valid 0", out_insn, out_valid); end
    drive(1, 32'h00100073, 0, 0, 64'h0);
    tests++; if (out_stall_from_icache !== 1'b0) begin fails++; $display("FAIL wrap_stall_resp got %b exp 0", out_stall_from_icache); end
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_insn !== 32'h00100073 || out_valid !== 1'b1) begin fails++; $display("FAIL wrap_ifid got %h/%h/%b exp fffffffffffffffc/00100073/1", out_pc, out_insn, out_valid); end
    tests++; if (out_icache_addr !== 64'h0) begin fails++; $display("FAIL wrap_addr got %h exp 0", out_icache_addr); end
    $display("[TB] pc wrap checked");
  endtask

  task automatic test_async_reset();
    drive(1, 32'h00208233, 1, 0, 64'h0);
    drive(0, 32'h0, 1, 0, 64'h0);
    tests++; if (out_icache_req !== 1'b0 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL areset_in_hold got req=%b pc=%h exp 0/fffffffffffffffc", out_icache_req, out_pc); end
    #2; reset_n = 1'b0; #1;
    tests++; if (out_valid !== 1'b0 || out_insn !== 32'h00000013 || out_pc !== 64'h0) begin fails++; $display("FAIL areset_ifid got %h/%h/%b exp 0/00000013/0", out_pc, out_insn, out_valid); end
    tests++; if (out_icache_addr !== 64'h1000 || out_icache_req !== 1'b0) begin fails++; $display("FAIL areset_pc got addr=%h req=%b exp 1000/0", out_icache_addr, out_icache_req); end
    in_stall = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_icache_req !== 1'b1 || out_icache_addr !== 64'h1000 || out_valid !== 1'b0) begin fails++; $display("FAIL areset_restart got req=%b addr=%h valid=%b exp 1/1000/0", out_icache_req, out_icache_addr, out_valid); end
    drive(1, 32'h00500093, 0, 0, 64'h0);
    drive(0, 32'h0, 0, 0, 64'h0);
    tests++; if (out_pc !== 64'h1000 || out_insn !== 32'h00500093 || out_valid !== 1'b1) begin fails++; $display("FAIL areset_refetch got %h/%h/%b exp 1000/00500093/1", out_pc, out_insn, out_valid); end
    $display("[TB] async reset mid-hold checked");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_with_resp();
    test_redirect_discard();
    test_pc_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
